// File: rtl/riscv_core_pkg.sv
// riscv_core_pkg: shared loader state encoding and word geometry
package riscv_core_pkg;
  localparam int LDR_ILEN = 32;
  localparam int LDR_MWID = 8;
  localparam int BYTES_PER_WORD = LDR_ILEN / LDR_MWID;
  typedef enum logic [1:0] {LDR_IDLE, LDR_LOAD, LDR_DONE} loader_state_e;
endpackage

// File: rtl/riscv_core_byte_packer.sv
// riscv_core_byte_packer: gathers stream bytes into lanes of one word and reports the word including the current byte
module riscv_core_byte_packer #(
  parameter int MWID = 8,
  parameter int SW = 4,
  parameter int LW = $clog2(SW)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             flush_i,
  input  logic [LW-1:0]    lane_i,
  input  logic [MWID-1:0]  data_i,
  output logic [SW*MWID-1:0] word_o,
  output logic [SW-1:0]    strb_o
);
  logic [SW*MWID-1:0] buf_q;
  logic [SW-1:0] strb_q;
  always_comb begin
    word_o = buf_q;
    strb_o = strb_q;
    word_o[lane_i*MWID +: MWID] = data_i;
    strb_o[lane_i] = 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      buf_q <= '0;
      strb_q <= '0;
    end else if (push_i) begin
      buf_q <= flush_i ? '0 : word_o;
      strb_q <= flush_i ? '0 : strb_o;
    end
  end
endmodule

// File: rtl/riscv_core_imem_loader.sv
// riscv_core_imem_loader: packs a boot byte stream into imem words and holds the core in reset until loaded
module riscv_core_imem_loader
  import riscv_core_pkg::*;
#(
  parameter int ALEN = 64,
  parameter int ILEN = LDR_ILEN,
  parameter int MWID = LDR_MWID,
  parameter int MLEN = 256,
  parameter int CNTW = $clog2(MLEN) + 1
) (
  input  logic                 i_loader_clk,
  input  logic                 i_loader_rst_n,
  input  logic                 i_start,
  input  logic [ALEN-1:0]      i_base_addr,
  input  logic [CNTW-1:0]      i_num_bytes,
  input  logic                 i_s_valid,
  input  logic [MWID-1:0]      i_s_data,
  output logic                 o_s_ready,
  output logic                 o_wr_en,
  output logic [ALEN-1:0]      o_wr_addr,
  output logic [ILEN-1:0]      o_wr_data,
  output logic [ILEN/MWID-1:0] o_wr_strb,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_core_rst_n
);
  localparam int SW = ILEN / MWID;
  localparam int LW = $clog2(SW);
  loader_state_e state_q, state_d;
  logic [ALEN-1:0] base_q, wr_addr_q;
  logic [CNTW-1:0] num_q, cnt_q;
  logic [ILEN-1:0] wr_data_q, pk_word;
  logic [SW-1:0] wr_strb_q, pk_strb;
  logic err_q, wr_en_q, core_rst_n_q;
  logic bad, xfer, last, flush;
  logic [LW-1:0] lane;
  assign lane = cnt_q[LW-1:0];
  // window check is done one bit wider than the address so base+num cannot wrap
  assign bad = (|i_base_addr[1:0]) ||
               (({1'b0, i_base_addr} + (ALEN+1)'(i_num_bytes)) > (ALEN+1)'(MLEN));
  assign xfer = (state_q == LDR_LOAD) && i_s_valid;
  assign last = xfer && ((cnt_q + CNTW'(1)) == num_q);
  assign flush = xfer && ((lane == LW'(SW-1)) || last);
  assign state_d = state_q == LDR_IDLE ? (i_start ? ((bad || i_num_bytes == '0) ? LDR_DONE : LDR_LOAD) : LDR_IDLE)
                 : state_q == LDR_LOAD ? (last ? LDR_DONE : LDR_LOAD)
                 : LDR_IDLE;
  riscv_core_byte_packer #(.MWID(MWID), .SW(SW), .LW(LW)) u_packer (
    .clk_i  (i_loader_clk),
    .rst_n_i(i_loader_rst_n),
    .push_i (xfer),
    .flush_i(flush),
    .lane_i (lane),
    .data_i (i_s_data),
    .word_o (pk_word),
    .strb_o (pk_strb)
  );
  always_ff @(posedge i_loader_clk) begin
    if (!i_loader_rst_n) begin
      state_q <= LDR_IDLE;
      base_q <= '0;
      num_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == LDR_IDLE && i_start) begin
        base_q <= i_base_addr;
        num_q <= i_num_bytes;
        cnt_q <= '0;
        err_q <= bad;
      end
      if (xfer) cnt_q <= cnt_q + CNTW'(1);
      wr_en_q <= flush;
      if (flush) begin
        wr_addr_q <= base_q + ALEN'({cnt_q[CNTW-1:LW], LW'(0)});
        wr_data_q <= pk_word;
        wr_strb_q <= pk_strb;
      end
      if (state_q == LDR_DONE && !err_q) core_rst_n_q <= 1'b1;
    end
  end
  assign o_s_ready = state_q == LDR_LOAD;
  assign o_busy = state_q == LDR_LOAD;
  assign o_done = state_q == LDR_DONE;
  assign o_err = err_q;
  assign o_wr_en = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_wr_strb = wr_strb_q;
  assign o_core_rst_n = core_rst_n_q;
endmodule
